// File: rtl/riscv_v_result_pipe.sv
// Vector result pipeline EXE->MEM->WB: turns each EXE result into per-byte RF write
// enables (element size, vl, mask), stages it through MEM and WB, and counts retired writes.
module riscv_v_result_pipe #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_OSIZES = 5,
  parameter int VL_WIDTH   = 5,
  parameter int CNT_WIDTH  = 32,
  localparam int NUM_BYTES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic                  flush_exe,
  input  logic                  exe_valid,
  input  logic                  exe_rf_wr,
  input  logic                  exe_masked,
  input  logic [NUM_BYTES-1:0]  exe_mask,
  input  logic [NUM_OSIZES-1:0] exe_osize_vector,
  input  logic [VL_WIDTH-1:0]   exe_vl,
  input  logic [ADDR_WIDTH-1:0] exe_wr_addr,
  input  logic [DATA_WIDTH-1:0] exe_wr_data,
  output logic [NUM_BYTES-1:0]  rf_wr_en_mem,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr_mem,
  output logic [DATA_WIDTH-1:0] rf_wr_data_mem,
  output logic [NUM_BYTES-1:0]  rf_wr_en_wb,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr_wb,
  output logic [DATA_WIDTH-1:0] rf_wr_data_wb,
  output logic [CNT_WIDTH-1:0]  retired_cnt
);

  localparam int KW = (NUM_OSIZES > 1) ? $clog2(NUM_OSIZES) : 1;
  localparam int EW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic [KW-1:0]         osize_k;
  logic [EW-1:0]         elem;
  logic [NUM_BYTES-1:0]  exe_en;

  logic                  mem_vld_q, mem_vld_d;
  logic [NUM_BYTES-1:0]  mem_en_q, mem_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  wb_vld_q, wb_vld_d;
  logic [NUM_BYTES-1:0]  wb_en_q, wb_en_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // EXE: byte b belongs to element b>>k; elements beyond the register are never reachable,
  // so an oversized vl clamps naturally.
  always_comb begin
    osize_k = '0;
    elem    = '0;
    exe_en  = '0;
    for (int i = 0; i < NUM_OSIZES; i++) begin
      if (exe_osize_vector[i]) osize_k = KW'(i);
    end
    for (int b = 0; b < NUM_BYTES; b++) begin
      elem = EW'(b) >> osize_k;
      if ((VL_WIDTH'(elem) < exe_vl) && (!exe_masked || exe_mask[elem])) exe_en[b] = 1'b1;
    end
    if (!(exe_valid && exe_rf_wr && $onehot(exe_osize_vector))) exe_en = '0;
  end

  always_comb begin
    mem_vld_d  = mem_vld_q;
    mem_en_d   = mem_en_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wb_vld_d   = wb_vld_q;
    wb_en_d    = wb_en_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    cnt_d      = cnt_q;
    if (!stall) begin
      wb_vld_d  = mem_vld_q;
      wb_en_d   = mem_en_q;
      wb_addr_d = mem_addr_q;
      wb_data_d = mem_data_q;
      if (wb_vld_q) cnt_d = cnt_q + CNT_WIDTH'(1);
      // Bubbles leave addr/data untouched; only the enables are cleared.
      if (!flush_exe && (exe_en != '0)) begin
        mem_vld_d  = 1'b1;
        mem_en_d   = exe_en;
        mem_addr_d = exe_wr_addr;
        mem_data_d = exe_wr_data;
      end else begin
        mem_vld_d = 1'b0;
        mem_en_d  = '0;
      end
    end
  end

  // MEM / WB stage registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_vld_q  <= 1'b0;
      mem_en_q   <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      wb_vld_q   <= 1'b0;
      wb_en_q    <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      mem_vld_q  <= mem_vld_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      wb_vld_q   <= wb_vld_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rf_wr_en_mem   = mem_vld_q ? mem_en_q : '0;
  assign rf_wr_addr_mem = mem_addr_q;
  assign rf_wr_data_mem = mem_data_q;
  assign rf_wr_en_wb    = wb_vld_q ? wb_en_q : '0;
  assign rf_wr_addr_wb  = wb_addr_q;
  assign rf_wr_data_wb  = wb_data_q;
  assign retired_cnt    = cnt_q;

endmodule
